// File: rtl/instr_prefetch_unit.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue, credit-based request issue
// and redirect handling that flushes the queue and discards stale in-flight responses.
module instr_prefetch_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_valid,
    input  logic [XLEN-1:0]   resp_data,
    input  logic              resp_err,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [XLEN-1:0]   instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_err,
    output logic              busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [XLEN-1:0]   data;
        logic              err;
    } entry_t;

    entry_t             r_queue [DEPTH];
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_resp_pc;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;

    logic               w_credit;
    logic               w_req_valid;
    logic               w_fire;
    logic               w_pop;
    logic               w_drop;
    logic               w_push;
    logic [ADDR_W-1:0]  w_redirect_pc;
    entry_t             w_head;

    // Queue slots already taken plus requests in flight must leave room for every response
    assign w_credit      = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CNT_W + 1)'(DEPTH);
    // Gated by reset_n so the request channel is quiet while reset is held
    assign w_req_valid   = reset_n & fetch_en & ~redirect_valid
                         & (r_outstanding < CNT_W'(MAX_OUT)) & w_credit;
    assign w_fire        = w_req_valid & req_ready;
    assign w_pop         = instr_valid & instr_ready;
    assign w_drop        = resp_valid & (r_drop_cnt != '0);
    assign w_push        = resp_valid & ~w_drop;
    assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);
    assign w_head        = r_queue[r_rptr];

    assign req_valid   = w_req_valid;
    assign req_addr    = r_fetch_pc;
    assign instr_valid = (r_count != '0);
    assign instr_data  = w_head.data;
    assign instr_pc    = w_head.pc;
    assign instr_err   = w_head.err;
    assign busy        = (r_outstanding != '0) | (r_drop_cnt != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_queue[i] <= '0;
            end
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_fire) - CNT_W'(resp_valid);
            if (redirect_valid) begin
                // Everything still in flight belongs to the old stream
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_drop_cnt <= r_outstanding - CNT_W'(resp_valid);
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
                if (w_push) begin
                    r_queue[r_wptr] <= '{pc: r_resp_pc, data: resp_data, err: resp_err};
                    r_wptr          <= r_wptr + PTR_W'(1);
                    r_resp_pc       <= r_resp_pc + ADDR_W'(4);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

endmodule
